// File: rtl/i2c_apb_fifo.sv
// APB register front end with command, TX and RX FIFOs for an I2C master core.
// Define I2C_APB_FIFO_IRQ_EN to build the interrupt register at 0x14.
module i2c_apb_fifo_buf #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         arst_n,
    input  logic                         push_i,
    input  logic [W-1:0]                 data_i,
    input  logic                         pop_i,
    output logic [W-1:0]                 data_o,
    output logic                         valid_o,
    output logic                         full_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_q, wr_d;
    logic [PW-1:0] rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          push_ok;
    logic          pop_ok;

    // Full is judged on the pre-pop count, so a pop never frees a slot early.
    assign full_o  = (cnt_q == CW'(DEPTH));
    assign valid_o = (cnt_q != '0);
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & valid_o;
    assign data_o  = mem_q[rd_q];
    assign count_o = cnt_q;

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (push_ok) wr_d = wr_q + 1'b1;
        if (pop_ok)  rd_d = rd_q + 1'b1;
        case ({push_ok, pop_ok})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_q] <= data_i;
    end
endmodule

module i2c_apb_fifo #(
    parameter int CMD_DEPTH  = 4,
    parameter int DATA_DEPTH = 16
) (
    input  logic        clk,
    input  logic        arst_n,
    input  logic        s_apb_psel,
    input  logic        s_apb_penable,
    input  logic        s_apb_pwrite,
    input  logic [5:0]  s_apb_paddr,
    input  logic [31:0] s_apb_pwdata,
    output logic        s_apb_pready,
    output logic [31:0] s_apb_prdata,
    output logic        s_apb_pslverr,
    output logic [6:0]  m_cmd_address,
    output logic [4:0]  m_cmd_flags,
    output logic        m_cmd_valid,
    input  logic        m_cmd_ready,
    output logic [7:0]  m_data_tdata,
    output logic        m_data_tlast,
    output logic        m_data_tvalid,
    input  logic        m_data_tready,
    input  logic [7:0]  s_data_tdata,
    input  logic        s_data_tvalid,
    output logic        s_data_tready,
    input  logic [3:0]  status_i,
    output logic [15:0] prescale_o,
    output logic        stop_on_idle_o,
    output logic        irq
);
    localparam int CCW = $clog2(CMD_DEPTH+1);
    localparam int DCW = $clog2(DATA_DEPTH+1);

    logic            acc;
    logic [3:0]      idx;
    logic [16:0]     ctrl_q, ctrl_d;
    logic            cmd_push, tx_push, rx_pop;
    logic            cmd_full, tx_full, rx_full;
    logic            rx_valid;
    logic [7:0]      rx_data;
    logic [11:0]     cmd_head;
    logic [8:0]      tx_head;
    logic [CCW-1:0]  cmd_cnt;
    logic [DCW-1:0]  tx_cnt, rx_cnt;
    logic [31:0]     status_w;
    logic            unused_w;
`ifdef I2C_APB_FIFO_IRQ_EN
    logic            irq_wr;
    logic [2:0]      pend_q, pend_d;
    logic [2:0]      en_q, en_d;
    logic            irq_q;
    logic            miss_q, busy_q;
    logic            done;
`endif

    assign acc          = s_apb_psel & s_apb_penable;
    assign idx          = s_apb_paddr[5:2];
    assign s_apb_pready = 1'b1;
    assign unused_w     = ^{s_apb_paddr[1:0], s_apb_pwdata};

    assign prescale_o     = ctrl_q[15:0];
    assign stop_on_idle_o = ctrl_q[16];
    assign status_w = {8'(rx_cnt), 8'(tx_cnt), 8'(cmd_cnt), 4'b0, status_i};

    always_comb begin
        s_apb_prdata  = '0;
        s_apb_pslverr = 1'b0;
        cmd_push      = 1'b0;
        tx_push       = 1'b0;
        rx_pop        = 1'b0;
        ctrl_d        = ctrl_q;
`ifdef I2C_APB_FIFO_IRQ_EN
        irq_wr        = 1'b0;
`endif
        if (acc) begin
            case (idx)
                4'd0: begin
                    if (s_apb_pwrite) ctrl_d = s_apb_pwdata[16:0];
                    else s_apb_prdata = {15'b0, ctrl_q};
                end
                4'd1: begin
                    if (s_apb_pwrite) s_apb_pslverr = 1'b1;
                    else s_apb_prdata = status_w;
                end
                4'd2: begin
                    if (!s_apb_pwrite || cmd_full) s_apb_pslverr = 1'b1;
                    else cmd_push = 1'b1;
                end
                4'd3: begin
                    if (!s_apb_pwrite || tx_full) s_apb_pslverr = 1'b1;
                    else tx_push = 1'b1;
                end
                4'd4: begin
                    if (s_apb_pwrite || !rx_valid) begin
                        s_apb_pslverr = 1'b1;
                    end else begin
                        s_apb_prdata = {23'b0, 1'b1, rx_data};
                        rx_pop       = 1'b1;
                    end
                end
                4'd5: begin
`ifdef I2C_APB_FIFO_IRQ_EN
                    if (s_apb_pwrite) irq_wr = 1'b1;
                    else s_apb_prdata = {21'b0, en_q, 5'b0, pend_q};
`else
                    s_apb_prdata = '0;
`endif
                end
                default: s_apb_pslverr = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) ctrl_q <= 17'h000FA;
        else         ctrl_q <= ctrl_d;
    end

    i2c_apb_fifo_buf #(.W(12), .DEPTH(CMD_DEPTH)) u_cmd (
        .clk     (clk),
        .arst_n  (arst_n),
        .push_i  (cmd_push),
        .data_i  ({s_apb_pwdata[12:8], s_apb_pwdata[6:0]}),
        .pop_i   (m_cmd_ready),
        .data_o  (cmd_head),
        .valid_o (m_cmd_valid),
        .full_o  (cmd_full),
        .count_o (cmd_cnt)
    );

    assign m_cmd_flags   = cmd_head[11:7];
    assign m_cmd_address = cmd_head[6:0];

    i2c_apb_fifo_buf #(.W(9), .DEPTH(DATA_DEPTH)) u_tx (
        .clk     (clk),
        .arst_n  (arst_n),
        .push_i  (tx_push),
        .data_i  (s_apb_pwdata[8:0]),
        .pop_i   (m_data_tready),
        .data_o  (tx_head),
        .valid_o (m_data_tvalid),
        .full_o  (tx_full),
        .count_o (tx_cnt)
    );

    assign m_data_tlast = tx_head[8];
    assign m_data_tdata = tx_head[7:0];

    i2c_apb_fifo_buf #(.W(8), .DEPTH(DATA_DEPTH)) u_rx (
        .clk     (clk),
        .arst_n  (arst_n),
        .push_i  (s_data_tvalid),
        .data_i  (s_data_tdata),
        .pop_i   (rx_pop),
        .data_o  (rx_data),
        .valid_o (rx_valid),
        .full_o  (rx_full),
        .count_o (rx_cnt)
    );

    assign s_data_tready = ~rx_full;

`ifdef I2C_APB_FIFO_IRQ_EN
    // Transfer is done when the core drops busy with nothing left queued.
    assign done = busy_q & ~status_i[0] & ~m_cmd_valid;

    always_comb begin
        pend_d = pend_q;
        en_d   = en_q;
        if (irq_wr) begin
            pend_d = pend_q & ~s_apb_pwdata[2:0];
            en_d   = s_apb_pwdata[10:8];
        end
        pend_d = pend_d | {done, rx_valid, status_i[3] & ~miss_q};
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            pend_q <= '0;
            en_q   <= '0;
            irq_q  <= 1'b0;
            miss_q <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            pend_q <= pend_d;
            en_q   <= en_d;
            irq_q  <= |(pend_q & en_q);
            miss_q <= status_i[3];
            busy_q <= status_i[0];
        end
    end

    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif
endmodule

// File: tb/tb_i2c_apb_fifo.sv
// Directed self-checking bench for i2c_apb_fifo (default depths 4/16).
module tb_i2c_apb_fifo;
    logic        clk = 1'b0;
    logic        arst_n;
    logic        psel, penable, pwrite;
    logic [5:0]  paddr;
    logic [31:0] pwdata;
    logic        pready;
    logic [31:0] prdata;
    logic        pslverr;
    logic [6:0]  cmd_addr;
    logic [4:0]  cmd_flags;
    logic        cmd_valid, cmd_ready;
    logic [7:0]  tx_data;
    logic        tx_last, tx_valid, tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid, rx_ready;
    logic [3:0]  status;
    logic [15:0] prescale;
    logic        stop_idle;
    logic        irq;

    int n_chk  = 0;
    int n_fail = 0;

    logic        err;
    logic        err_acc;
    logic [31:0] rd;

    always #5 clk = ~clk;

    i2c_apb_fifo dut (
        .clk            (clk),
        .arst_n         (arst_n),
        .s_apb_psel     (psel),
        .s_apb_penable  (penable),
        .s_apb_pwrite   (pwrite),
        .s_apb_paddr    (paddr),
        .s_apb_pwdata   (pwdata),
        .s_apb_pready   (pready),
        .s_apb_prdata   (prdata),
        .s_apb_pslverr  (pslverr),
        .m_cmd_address  (cmd_addr),
        .m_cmd_flags    (cmd_flags),
        .m_cmd_valid    (cmd_valid),
        .m_cmd_ready    (cmd_ready),
        .m_data_tdata   (tx_data),
        .m_data_tlast   (tx_last),
        .m_data_tvalid  (tx_valid),
        .m_data_tready  (tx_ready),
        .s_data_tdata   (rx_data),
        .s_data_tvalid  (rx_valid),
        .s_data_tready  (rx_ready),
        .status_i       (status),
        .prescale_o     (prescale),
        .stop_on_idle_o (stop_idle),
        .irq            (irq)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic apb_wr(input logic [5:0] a, input logic [31:0] d,
                          input logic pop_tx, output logic e);
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
        paddr = a; pwdata = d;
        @(posedge clk); #1;
        penable = 1'b1;
        tx_ready = pop_tx;
        #1 e = pslverr;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; tx_ready = 1'b0;
    endtask

    task automatic apb_rd(input logic [5:0] a, output logic [31:0] d,
                          output logic e);
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
        @(posedge clk); #1;
        penable = 1'b1;
        #1 d = prdata; e = pslverr;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    initial begin
        arst_n = 1'b0;
        psel = 0; penable = 0; pwrite = 0; paddr = '0; pwdata = '0;
        cmd_ready = 0; tx_ready = 0; rx_data = '0; rx_valid = 0;
        status = '0;
        #12;
        chk("rst_cmd_valid", 32'(cmd_valid), 32'd0);
        chk("rst_tx_valid", 32'(tx_valid), 32'd0);
        chk("rst_rx_ready", 32'(rx_ready), 32'd1);
        chk("rst_pslverr", 32'(pslverr), 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_prescale", 32'(prescale), 32'hFA);
        chk("rst_stop", 32'(stop_idle), 32'd0);
        #10 arst_n = 1'b1;
        apb_rd(6'h00, rd, err);
        chk("ctrl_rst", rd, 32'hFA);
        chk("pready", 32'(pready), 32'd1);

        status = 4'h5;
        apb_wr(6'h08, 32'h0150, 1'b0, err);
        chk("cmd_wr_err", 32'(err), 32'd0);
        apb_wr(6'h0C, 32'h01A5, 1'b0, err);
        chk("tx_wr_err", 32'(err), 32'd0);
        chk("cmd_addr", 32'(cmd_addr), 32'h50);
        chk("cmd_flags", 32'(cmd_flags), 32'h01);
        chk("cmd_valid", 32'(cmd_valid), 32'd1);
        chk("tx_data", 32'(tx_data), 32'hA5);
        chk("tx_last", 32'(tx_last), 32'd1);
        chk("tx_valid", 32'(tx_valid), 32'd1);
        apb_rd(6'h04, rd, err);
        chk("status_1", rd, 32'h0001_0105);
        status = 4'h0;

        err_acc = 1'b0;
        for (int i = 1; i <= 15; i++) begin
            apb_wr(6'h0C, 32'(i), 1'b0, err);
            err_acc |= err;
        end
        chk("tx_fill_err", 32'(err_acc), 32'd0);
        apb_wr(6'h0C, 32'h77, 1'b0, err);
        chk("tx_17th_err", 32'(err), 32'd1);
        apb_rd(6'h04, rd, err);
        chk("status_full", rd, 32'h0010_0100);

        apb_wr(6'h0C, 32'h88, 1'b1, err);
        chk("tx_pushpop_err", 32'(err), 32'd1);
        apb_rd(6'h04, rd, err);
        chk("status_15", rd, 32'h000F_0100);
        chk("tx_head2", 32'(tx_data), 32'h01);
        chk("tx_last2", 32'(tx_last), 32'd0);

        tx_ready = 1'b1;
        for (int n = 0; n < 40 && tx_valid; n++) begin
            @(posedge clk); #1;
        end
        tx_ready = 1'b0;
        chk("tx_drained", 32'(tx_valid), 32'd0);
        apb_rd(6'h04, rd, err);
        chk("status_drained", rd, 32'h0000_0100);

        apb_wr(6'h08, 32'h0251, 1'b0, err);
        apb_wr(6'h08, 32'h0352, 1'b0, err);
        apb_wr(6'h08, 32'h0453, 1'b0, err);
        chk("cmd_4th_err", 32'(err), 32'd0);
        apb_wr(6'h08, 32'h1F7F, 1'b0, err);
        chk("cmd_5th_err", 32'(err), 32'd1);
        apb_rd(6'h04, rd, err);
        chk("status_cmd4", rd, 32'h0000_0400);
        cmd_ready = 1'b1;
        @(posedge clk); #1;
        cmd_ready = 1'b0;
        chk("cmd_addr2", 32'(cmd_addr), 32'h51);
        chk("cmd_flags2", 32'(cmd_flags), 32'h02);

        apb_wr(6'h00, 32'h0001_1234, 1'b0, err);
        chk("prescale_wr", 32'(prescale), 32'h1234);
        chk("stop_wr", 32'(stop_idle), 32'd1);
        apb_rd(6'h00, rd, err);
        chk("ctrl_rd", rd, 32'h0001_1234);

        #2 arst_n = 1'b0;
        #1;
        chk("arst_cmd_valid", 32'(cmd_valid), 32'd0);
        chk("arst_prescale", 32'(prescale), 32'hFA);
        chk("arst_stop", 32'(stop_idle), 32'd0);
        @(posedge clk); #3 arst_n = 1'b1;
        apb_rd(6'h00, rd, err);
        chk("ctrl_after_rst", rd, 32'hFA);
        apb_rd(6'h04, rd, err);
        chk("status_after_rst", rd, 32'h0);

        @(posedge clk); #1;
        rx_data = 8'h3C; rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
        apb_rd(6'h10, rd, err);
        chk("rx_rd1", rd, 32'h13C);
        chk("rx_rd1_err", 32'(err), 32'd0);
        apb_rd(6'h10, rd, err);
        chk("rx_rd2", rd, 32'h0);
        chk("rx_rd2_err", 32'(err), 32'd1);

        apb_rd(6'h08, rd, err);
        chk("rd_wo_err", 32'(err), 32'd1);
        apb_wr(6'h04, 32'h1, 1'b0, err);
        chk("wr_ro_err", 32'(err), 32'd1);
        apb_rd(6'h18, rd, err);
        chk("unmapped_err", 32'(err), 32'd1);
        apb_wr(6'h10, 32'h0, 1'b0, err);
        chk("wr_rx_err", 32'(err), 32'd1);

`ifdef I2C_APB_FIFO_IRQ_EN
        apb_wr(6'h14, 32'h100, 1'b0, err);
        chk("irq_en_err", 32'(err), 32'd0);
        status = 4'h8;
        @(posedge clk); #1;
        status = 4'h0;
        repeat (3) @(posedge clk);
        #1 chk("irq_set", 32'(irq), 32'd1);
        apb_wr(6'h14, 32'h101, 1'b0, err);
        repeat (2) @(posedge clk);
        #1 chk("irq_clr", 32'(irq), 32'd0);
        apb_rd(6'h14, rd, err);
        chk("irq_reg", rd, 32'h0000_0102);
`else
        apb_wr(6'h14, 32'h101, 1'b0, err);
        chk("irq_wr_err", 32'(err), 32'd0);
        apb_rd(6'h14, rd, err);
        chk("irq_rd", rd, 32'h0);
        chk("irq_rd_err", 32'(err), 32'd0);
        chk("irq_tied", 32'(irq), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
